// File: rtl/parity_mem_responder_pkg.sv
// Shared types for the parity memory responder: FSM states, stored word and
// the parity helpers used to build and check stored words.
package parity_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // {parity, data}
  typedef logic [8:0] word_t;

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

  // Build a stored word; flip inverts the parity bit to plant an error.
  function automatic word_t make_word(input logic [7:0] d, input logic flip);
    return {parity8(d) ^ flip, d};
  endfunction

endpackage

// File: rtl/parity_mem_responder_if.sv
// Request/response bundle between a requester (master) and the responder (slave).
interface parity_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 16
) ();
  import parity_mem_responder_pkg::*;

  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [7:0]        data_in;
  logic              inject_err;

  word_t             data_out;
  logic              data_valid;
  logic              busy;
  logic              parity_err;
  logic              uninit;
  logic [ERR_W-1:0]  error_count;
  logic [ERR_W-1:0]  collision_count;

  modport master (
    output write, read, address, data_in, inject_err,
    input  data_out, data_valid, busy, parity_err, uninit,
           error_count, collision_count
  );

  modport slave (
    input  write, read, address, data_in, inject_err,
    output data_out, data_valid, busy, parity_err, uninit,
           error_count, collision_count
  );

endinterface

// File: rtl/parity_mem_responder_array.sv
// Word storage with one write port and a registered read port; shares one
// address because reads and writes happen in different FSM states.
module parity_mem_array
  import parity_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  word_t             wdata_i,
  output word_t             rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  word_t mem_q [DEPTH];
  word_t rdata_q;

  // NOTE: storage has no reset so it maps onto plain RAM; the owner's valid
  // bits decide whether a read word is meaningful.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/parity_mem_responder.sv
// Single-port parity-protected memory responder: one-cycle writes, two-cycle
// reads, per-entry valid bits, saturating parity-error and collision counters.
module parity_mem_responder
  import parity_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  parity_mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              inject_q;
  logic [DEPTH-1:0]  valid_q;
  logic              rd_valid_q;
  word_t             rd_word;

  word_t             data_out_q;
  logic              data_valid_q;
  logic              parity_err_q;
  logic              uninit_q;
  logic [ERR_W-1:0]  error_count_q, error_count_d;
  logic [ERR_W-1:0]  collision_count_q, collision_count_d;

  logic              busy;
  logic              accept;
  logic              collide;
  logic              mem_we;
  logic              mem_re;
  logic              resp_fire;
  word_t             resp_word;
  logic              resp_perr;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.write && !bus.read)      state_d = WRITE;
        else if (bus.read && !bus.write) state_d = READ;
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    accept    = (state_q == IDLE) && (bus.write ^ bus.read);
    collide   = (state_q == IDLE) && bus.write && bus.read;
    mem_we    = (state_q == WRITE);
    mem_re    = (state_q == READ);
    resp_fire = (state_q == RESP);
  end

  // ------------------------------------------------------------ storage
  parity_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q),
    .wdata_i (make_word(wdata_q, inject_q)),
    .rdata_o (rd_word)
  );

  // Never-written entries answer zero and are never flagged as parity errors.
  assign resp_word = rd_valid_q ? rd_word : '0;
  assign resp_perr = rd_valid_q && (rd_word[8] != parity8(rd_word[7:0]));

  // ----------------------------------------------------------- counters
  always_comb begin
    error_count_d     = error_count_q;
    collision_count_d = collision_count_q;
    if (resp_fire && resp_perr && (error_count_q != '1))
      error_count_d = error_count_q + ERR_W'(1);
    if (collide && (collision_count_q != '1))
      collision_count_d = collision_count_q + ERR_W'(1);
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q            <= '0;
      wdata_q           <= '0;
      inject_q          <= 1'b0;
      valid_q           <= '0;
      rd_valid_q        <= 1'b0;
      data_out_q        <= '0;
      data_valid_q      <= 1'b0;
      parity_err_q      <= 1'b0;
      uninit_q          <= 1'b0;
      error_count_q     <= '0;
      collision_count_q <= '0;
    end else begin
      if (accept) begin
        addr_q   <= bus.address;
        wdata_q  <= bus.data_in;
        inject_q <= bus.inject_err;
      end
      if (mem_we) valid_q[addr_q] <= 1'b1;
      if (mem_re) rd_valid_q <= valid_q[addr_q];
      if (resp_fire) data_out_q <= resp_word;
      data_valid_q      <= resp_fire;
      parity_err_q      <= resp_fire && resp_perr;
      uninit_q          <= resp_fire && !rd_valid_q;
      error_count_q     <= error_count_d;
      collision_count_q <= collision_count_d;
    end
  end

  assign bus.data_out        = data_out_q;
  assign bus.data_valid      = data_valid_q;
  assign bus.busy            = busy;
  assign bus.parity_err      = parity_err_q;
  assign bus.uninit          = uninit_q;
  assign bus.error_count     = error_count_q;
  assign bus.collision_count = collision_count_q;

endmodule

// File: tb/tb_parity_mem_responder.sv
// Directed plus randomized checks of parity_mem_responder against an
// array-based reference model of the memory, valid bits and counters.
module tb_parity_mem_responder;

  localparam int ADDR_W  = 8;
  localparam int ERR_W   = 4;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int CNT_MAX = 2 ** ERR_W - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  parity_mem_responder_if #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) bus ();

  parity_mem_responder #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [8:0] ref_mem   [DEPTH];
  bit         ref_valid [DEPTH];
  int         ref_err;
  int         ref_coll;
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  function automatic bit odd_ones(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  // Expected response {uninit, parity_err, data_out} for a read of a.
  function automatic logic [10:0] expect_resp(input logic [ADDR_W-1:0] a);
    logic [8:0] w;
    if (!ref_valid[a]) return {1'b1, 1'b0, 9'h000};
    w = ref_mem[a];
    return {1'b0, (w[8] != odd_ones(w[7:0])), w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.inject_err = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
    ref_err  = 0;
    ref_coll = 0;
  endtask

  task automatic write_op(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit inj);
    bus.write = 1'b1; bus.read = 1'b0;
    bus.address = a; bus.data_in = d; bus.inject_err = inj;
    tick();
    drive_idle();
    check("wr_busy_set", bus.busy, 1);
    tick();
    check("wr_busy_clr", bus.busy, 0);
    ref_mem[a]   = {odd_ones(d) ^ inj, d};
    ref_valid[a] = 1'b1;
  endtask

  task automatic read_op(input logic [ADDR_W-1:0] a);
    logic [10:0] e;
    e = expect_resp(a);
    bus.read = 1'b1; bus.write = 1'b0; bus.address = a;
    tick();
    drive_idle();
    check("rd_busy_set", bus.busy, 1);
    check("rd_dv_k", bus.data_valid, 0);
    tick();
    check("rd_dv_k1", bus.data_valid, 0);
    tick();
    check("rd_dv_k2", bus.data_valid, 1);
    check("rd_data", bus.data_out, e[8:0]);
    check("rd_perr", bus.parity_err, e[9]);
    check("rd_uninit", bus.uninit, e[10]);
    if (e[9] && ref_err < CNT_MAX) ref_err++;
    check("rd_err_cnt", bus.error_count, ref_err);
    tick();
    check("rd_dv_drop", bus.data_valid, 0);
    check("rd_perr_drop", bus.parity_err, 0);
    check("rd_data_hold", bus.data_out, e[8:0]);
    check("rd_busy_clr", bus.busy, 0);
  endtask

  task automatic collide_op(input logic [ADDR_W-1:0] a);
    bus.write = 1'b1; bus.read = 1'b1;
    bus.address = a; bus.data_in = 8'($urandom);
    tick();
    drive_idle();
    if (ref_coll < CNT_MAX) ref_coll++;
    check("col_busy", bus.busy, 0);
    check("col_cnt", bus.collision_count, ref_coll);
  endtask

  initial begin
    logic [10:0] e;
    int op;

    drive_idle();
    bus.address = '0;
    bus.data_in = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_dv", bus.data_valid, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_uninit", bus.uninit, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_err_cnt", bus.error_count, 0);
    check("rst_col_cnt", bus.collision_count, 0);
    rst_n = 1'b1;
    tick();

    // Never-written top address, then the basic write/read pair (0x1234 truncates to 0x34).
    read_op(8'hFF);
    write_op(8'h34, 8'hA5, 1'b0);
    read_op(8'h34);
    check("a5_word", bus.data_out, 9'h0A5);

    // Planted parity error.
    write_op(8'h10, 8'h07, 1'b1);
    read_op(8'h10);
    check("inj_word", bus.data_out, 9'h007);
    check("inj_err_cnt", bus.error_count, 1);

    // Collision must not touch memory.
    collide_op(8'h55);
    read_op(8'h55);

    // Write presented while a read is busy is ignored.
    bus.read = 1'b1; bus.address = 8'h20;
    tick();
    bus.read = 1'b0; bus.write = 1'b1; bus.address = 8'h77; bus.data_in = 8'h33;
    tick();
    check("ign_busy", bus.busy, 1);
    tick();
    check("ign_dv", bus.data_valid, 1);
    check("ign_uninit", bus.uninit, 1);
    drive_idle();
    tick();
    read_op(8'h77);

    // Held read: accepted every third cycle.
    e = expect_resp(8'h34);
    bus.read = 1'b1; bus.address = 8'h34;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("b2b_dv", bus.data_valid, (c == 2 || c == 5) ? 1 : 0);
      if (c == 2 || c == 5) check("b2b_data", bus.data_out, e[8:0]);
    end
    drive_idle();
    tick();
    check("b2b_idle", bus.busy, 0);

    // Boundary addresses.
    write_op(8'hFF, 8'h80, 1'b0);
    write_op(8'h00, 8'hFE, 1'b0);
    read_op(8'hFF);
    read_op(8'h00);

    // Randomized mix on a small address window so reads hit written entries.
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 9);
      if (op < 4)      write_op(4'($urandom_range(0, 15)), 8'($urandom), bit'($urandom_range(0, 1)));
      else if (op < 8) read_op(4'($urandom_range(0, 15)));
      else if (op < 9) collide_op(4'($urandom_range(0, 15)));
      else             tick();
    end

    // Drive both counters to saturation.
    for (int n = 0; n < CNT_MAX + 3; n++) collide_op(8'hC0);
    check("col_sat", bus.collision_count, CNT_MAX);
    for (int n = 0; n < CNT_MAX + 2; n++) begin
      write_op(8'h90, 8'h01, 1'b1);
      read_op(8'h90);
    end
    check("err_sat", bus.error_count, CNT_MAX);

    // Asynchronous reset while the FSM sits in RESP.
    bus.read = 1'b1; bus.address = 8'h34;
    tick();
    drive_idle();
    tick();
    check("pre_rst_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy", bus.busy, 0);
    check("arst_dv", bus.data_valid, 0);
    check("arst_data", bus.data_out, 0);
    check("arst_err_cnt", bus.error_count, 0);
    check("arst_col_cnt", bus.collision_count, 0);
    tick();
    check("arst_no_resp", bus.data_valid, 0);
    rst_n = 1'b1;
    tick();
    read_op(8'h34);

    // Reset in the middle of a write leaves the entry uninitialised.
    bus.write = 1'b1; bus.address = 8'h40; bus.data_in = 8'h5A;
    tick();
    drive_idle();
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    read_op(8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_mem_responder.md
PARITY_MEM_RESPONDER -- requirements
Module: parity_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8; address width, depth 2**ADDR_W.
REQ-002 SHALL have parameter ERR_W, default 16; error/collision counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port write  input  1  write request, sampled only in IDLE.
REQ-006 SHALL have port read  input  1  read request, sampled only in IDLE.
REQ-007 SHALL have port address  input  ADDR_W  request address.
REQ-008 SHALL have port data_in  input  8  write data.
REQ-009 SHALL have port inject_err  input  1  when high with write, stored parity bit is inverted.
REQ-010 SHALL have port data_out  output  9  {parity, data} read response.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse qualifying data_out.
REQ-012 SHALL have port busy  output  1  high while a request is in progress.
REQ-013 SHALL have port parity_err  output  1  one-cycle pulse with data_valid on parity mismatch.
REQ-014 SHALL have port uninit  output  1  one-cycle pulse with data_valid when the address was never written.
REQ-015 SHALL have port error_count  output  ERR_W  saturating count of parity_err pulses.
REQ-016 SHALL have port collision_count  output  ERR_W  saturating count of simultaneous read+write requests.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, RESP; reset state IDLE.
REQ-018 IDLE: write&!read -> WRITE; read&!write -> READ; both -> stay IDLE, increment collision_count, no memory access; neither -> IDLE.
REQ-019 Accepting a request at edge k SHALL latch address, data_in, inject_err and set busy=1 after edge k.
REQ-020 WRITE: at edge k+1 store {^data_in ^ inject_err, data_in}, set valid bit of address, return to IDLE, busy=0.
REQ-021 READ: at edge k+1 register stored word and valid bit; -> RESP.
REQ-022 RESP: at edge k+2 drive data_out, data_valid=1; return to IDLE; busy=0 and data_valid=0 after edge k+3.
REQ-023 Read latency SHALL be exactly 2 cycles from accepting edge to data_valid; back-to-back reads SHALL accept every 3rd cycle.
REQ-024 Unwritten address read SHALL return data_out=9'h000, uninit=1, parity_err=0.
REQ-025 parity_err SHALL be 1 when data_out[8] != ^data_out[7:0] on a valid entry; error_count increments by 1, saturating at all-ones.
REQ-026 collision_count SHALL saturate at all-ones.
REQ-027 Requests while busy=1 SHALL be ignored with no state, counter or memory effect.
REQ-028 data_out SHALL hold its last value between responses.
REQ-029 Address wrap: no special case; 2**ADDR_W-1 is a normal address.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, busy=0, data_valid=0, parity_err=0, uninit=0, data_out=0, both counters 0, all valid bits 0.
REQ-031 Reset mid-WRITE SHALL not guarantee array contents; the entry SHALL read uninit (valid bit cleared).
REQ-032 Memory array contents SHALL not be reset; only valid bits are.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, word type (9 bits) and the parity function.
REQ-034 One sub-module, parity_mem_array (storage plus registered read port, no reset), SHALL be instantiated.

Verification
REQ-035 Write 0x1234->8'hA5, read 0x34 (ADDR_W=8) -> data_out=9'h0A5, data_valid 2 cycles after accept, parity_err=0.
REQ-036 Write 0x10 data 8'h07 with inject_err=1, read 0x10 -> data_out=9'h007, parity_err=1, error_count=1.
REQ-037 write=1 and read=1 in IDLE -> no access, collision_count=1, busy stays 0.
REQ-038 Read never-written 0xFF after reset -> data_out=9'h000, uninit=1.
REQ-039 Assert read, then write during busy -> write ignored, target address still uninit on later read.
REQ-040 rst_n low during RESP -> data_valid=0, counters 0, FSM IDLE on same cycle.
